lc3_bus_arbiter: RTL
====================

Name: lc3_bus_arbiter

Overview:
- Parametrised, registered successor to the LC-3 datapath bus multiplexer.
- Selects one of N_SRC gated sources onto a WIDTH-bit shared bus.
- Idle bus either drives zero or holds the last driven value.
- Detects and counts multi-gate contention; tracks the index of the last driver for debug and the control FSM.

Parameters:
- N_SRC, 4: number of gated sources; index 0=ALU, 1=PC, 2=MARMUX, 3=MDR in the default build.
- WIDTH, 16: bus data width.
- HOLD_LAST, 1: 1 = idle bus (no gate) re-drives the last valid value; 0 = idle bus drives all-zero.
- PRIORITY_ON_CONFLICT, 1: 1 = on contention the lowest-index asserted source wins; 0 = bus drives all-zero on contention.
- CNT_W, 8: width of the saturating contention counter.

Ports:
- Clk, input, 1: system clock, rising edge.
- Reset_n, input, 1: synchronous, active-low reset.
- src_data, input, N_SRC x WIDTH: packed source data; slice i belongs to source i.
- gate, input, N_SRC: per-source gate enables (GateALU, GatePC, GateMARMUX, GateMDR in the default build).
- clr_err, input, 1: clears the sticky contention flag and the counter.
- bus, output, WIDTH: combinational bus value, zero latency.
- bus_q, output, WIDTH: registered bus value, one-cycle latency.
- bus_driven, output, 1: combinational; at least one gate is asserted.
- last_src, output, clog2(N_SRC): index of the source that won the most recent driven cycle.
- conflict, output, 1: combinational; more than one gate is asserted this cycle.
- conflict_sticky, output, 1: registered; contention has occurred since reset or the last clr_err.
- conflict_cnt, output, CNT_W: registered saturating count of contention cycles.

Behaviour:
- Gate classes, decoded every cycle:
  - NONE: gate == 0.
  - ONE: exactly one bit set.
  - MULTI: two or more bits set.
- win_idx is the lowest set index of gate. Its value is don't-care under NONE.
- bus (combinational):
  - ONE: src_data[win_idx].
  - MULTI: src_data[win_idx] if PRIORITY_ON_CONFLICT=1, else 0.
  - NONE: hold_q if HOLD_LAST=1, else 0.
- The bus never drives Z or X. Tri-state is not used anywhere in the datapath.
- hold_q (internal register): loads bus on every ONE cycle, and on every MULTI cycle when PRIORITY_ON_CONFLICT=1. Otherwise it keeps its value.
- bus_q: loads bus every cycle, so bus_q(t+1) = bus(t).
- last_src: loads win_idx under the same condition as hold_q. It is unchanged under NONE.
- bus_driven = (gate != 0); conflict = MULTI. Both are purely combinational.
- conflict_sticky:
  - Set on any MULTI cycle.
  - Cleared by clr_err.
  - If MULTI and clr_err occur in the same cycle, set wins: sticky=1 next cycle.
- conflict_cnt:
  - Increments by 1 per MULTI cycle and saturates at 2^CNT_W-1 with no wrap.
  - clr_err forces it to 0.
  - If MULTI and clr_err occur in the same cycle, it becomes 1.
- Reset (Reset_n=0 at a rising Clk edge):
  - hold_q, bus_q, last_src, conflict_sticky and conflict_cnt all go to 0.
  - Reset overrides every other condition on that edge.
  - Combinational outputs keep following the inputs during reset. Under NONE with HOLD_LAST=1, bus reads 0 from the cycle after the reset edge.
- Reset asserted mid-stream: held values are lost, with no partial update. The first post-reset cycle behaves exactly as after power-up.
- N_SRC=1: last_src is 1 bit wide and stuck at 0; MULTI can never occur.
- No FSM beyond the registers above. The block is a datapath plus status registers.

Decomposition:
- Package lc3_bus_pkg contains:
  - Source index constants SRC_ALU=0, SRC_PC=1, SRC_MARMUX=2, SRC_MDR=3.
  - Default WORD_W=16.
  - Enum gate_class_t {GC_NONE, GC_ONE, GC_MULTI}.
- Sub-module bus_prio_enc (parameter N) is natural. It takes the gate vector and produces win_idx, any and multi, with the one-hot/multi detection done by population check.
- The top level holds the mux, the hold/status registers and the counter.

Test Plan (N_SRC=4, WIDTH=16, CNT_W=8 unless stated):
1. Single gate: src_data={D:0x4444, C:0x3333, B:0x2222, A:0x1111}, gate=0100 (MARMUX) -> bus=0x3333 same cycle; bus_q=0x3333 next cycle; last_src=2.
2. Idle hold: after case 1, gate=0000 with HOLD_LAST=1 -> bus=0x3333 and bus_driven=0. Repeat with HOLD_LAST=0 -> bus=0x0000 and last_src stays 2.
3. Contention: gate=1001 with PRIORITY_ON_CONFLICT=1 -> bus=0x1111, conflict=1; next cycle conflict_sticky=1, conflict_cnt=1. With PRIORITY_ON_CONFLICT=0 -> bus=0x0000 and hold_q unchanged.
4. Saturation and clear:
   - Hold gate=1111 for 260 cycles -> conflict_cnt stops at 255.
   - clr_err with gate=0001 -> cnt=0, sticky=0.
   - clr_err with gate=0011 -> cnt=1, sticky=1.
5. Reset mid-operation: drive gate=0001 (0xBEEF) for 3 cycles, pull Reset_n=0 for one edge, then gate=0000 with HOLD_LAST=1 -> bus_q=0, last_src=0, conflict_cnt=0, and bus reads 0x0000 on the next cycle.
6. Randomised regression: 10k random gate/src_data cycles checked against a reference model, asserting bus_q(t+1)==bus(t) and that bus never contains X/Z.

Source files
------------

// File: rtl/lc3_bus_pkg.sv
// Shared constants and types for the LC-3 style gated bus arbiter.
package lc3_bus_pkg;

   localparam int SRC_ALU    = 0;
   localparam int SRC_PC     = 1;
   localparam int SRC_MARMUX = 2;
   localparam int SRC_MDR    = 3;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      GC_NONE  = 2'd0,
      GC_ONE   = 2'd1,
      GC_MULTI = 2'd2
   } gate_class_t;

   // Source-index width; a single source still gets one (constant-zero) bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Lowest-index-wins encoder over the gate vector, with population-based any/multi flags.
// Purely combinational, zero latency; no backpressure.
module bus_prio_enc
   import lc3_bus_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]        gate,
   output logic [idx_w(N)-1:0] win_idx,
   output logic                any,
   output logic                multi
);

   localparam int IDX_W = idx_w(N);
   localparam int CW    = $clog2(N + 1) + 1;

   logic [CW-1:0] pop;

   always_comb begin
      win_idx = '0;
      pop     = '0;
      // Scan high to low so the lowest asserted index is the last write.
      for (int i = N - 1; i >= 0; i--) begin
         pop = pop + CW'(gate[i]);
         if (gate[i]) win_idx = IDX_W'(i);
      end
      any   = (pop != '0);
      multi = (pop > CW'(1));
   end

endmodule

// File: rtl/lc3_bus_arbiter.sv
// Gated N-source bus mux with idle hold, contention detection and saturating conflict count.
// bus/bus_driven/conflict are zero-latency; bus_q and status registers are one cycle; no backpressure.
module lc3_bus_arbiter
   import lc3_bus_pkg::*;
#(
   parameter int N_SRC                = 4,
   parameter int WIDTH                = WORD_W,
   parameter bit HOLD_LAST            = 1'b1,
   parameter bit PRIORITY_ON_CONFLICT = 1'b1,
   parameter int CNT_W                = 8
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic [N_SRC*WIDTH-1:0]    src_data,
   input  logic [N_SRC-1:0]          gate,
   input  logic                      clr_err,
   output logic [WIDTH-1:0]          bus,
   output logic [WIDTH-1:0]          bus_q,
   output logic                      bus_driven,
   output logic [idx_w(N_SRC)-1:0]   last_src,
   output logic                      conflict,
   output logic                      conflict_sticky,
   output logic [CNT_W-1:0]          conflict_cnt
);

   logic [idx_w(N_SRC)-1:0] win_idx;
   logic                    any;
   logic                    multi;
   gate_class_t             gc;
   logic [WIDTH-1:0]        src_arr [N_SRC];
   logic [WIDTH-1:0]        hold_q;
   logic                    load;

   bus_prio_enc #(.N(N_SRC)) u_enc (
      .gate    (gate),
      .win_idx (win_idx),
      .any     (any),
      .multi   (multi)
   );

   always_comb begin
      for (int i = 0; i < N_SRC; i++) src_arr[i] = src_data[i*WIDTH +: WIDTH];
   end

   always_comb begin
      gc = multi ? GC_MULTI : (any ? GC_ONE : GC_NONE);
   end

   always_comb begin
      bus = '0;
      case (gc)
         GC_ONE:   bus = src_arr[win_idx];
         GC_MULTI: bus = PRIORITY_ON_CONFLICT ? src_arr[win_idx] : '0;
         default:  bus = HOLD_LAST ? hold_q : '0;
      endcase
   end

   // A cycle counts as "driven" for hold/last_src only when a real source reached the bus.
   assign load       = (gc == GC_ONE) || ((gc == GC_MULTI) && PRIORITY_ON_CONFLICT);
   assign bus_driven = any;
   assign conflict   = multi;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         hold_q          <= '0;
         bus_q           <= '0;
         last_src        <= '0;
         conflict_sticky <= 1'b0;
         conflict_cnt    <= '0;
      end else begin
         bus_q <= bus;
         if (load) begin
            hold_q   <= bus;
            last_src <= win_idx;
         end
         if (multi)        conflict_sticky <= 1'b1;
         else if (clr_err) conflict_sticky <= 1'b0;
         // Clear and a same-cycle conflict leave a count of exactly one.
         if (clr_err)
            conflict_cnt <= multi ? CNT_W'(1) : '0;
         else if (multi && (conflict_cnt != {CNT_W{1'b1}}))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule
